// File: rtl/draw_port_arbiter_if.sv
// Plot-port bundle shared between the draw engines and draw_port_arbiter.
// The engines drive the master side. The arbiter uses the slave side.
interface draw_port_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic [N-1:0]   write_in;
    logic [N-1:0]   start;
    logic [N-1:0]   grant;
    logic [7:0]     x_out;
    logic [6:0]     y_out;
    logic [2:0]     colour_out;
    logic           plot_out;
    logic           busy;
    logic           timeout;

    modport master (
        output req, done, x_in, y_in, colour_in, write_in,
        input  start, grant, x_out, y_out, colour_out, plot_out, busy, timeout
    );

    modport slave (
        input  req, done, x_in, y_in, colour_in, write_in,
        output start, grant, x_out, y_out, colour_out, plot_out, busy, timeout
    );
endinterface

// File: rtl/draw_port_arbiter.sv
// Shares the VGA plot port among N draw engines, with a watchdog on each grant.
// By default the lowest index wins. Define DRAW_ARB_RR_EN to get round-robin arbitration.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate on any req
// LAUNCH  | owner granted, start pulse high for this one cycle, done ignored
// ACTIVE  | owner's pixels registered onto the port, watchdog counting
// RELEASE | last pixel still on the port; grant/busy/plot cleared on exit
module draw_port_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 19216,
    parameter int TO_W    = 15
) (
    input  logic               clk,
    input  logic               resetn,
    draw_port_arbiter_if.slave port
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, RELEASE} state_t;

    state_t          state;
    logic [IW-1:0]   g;
    logic [TO_W-1:0] wd;
    logic [IW-1:0]   win;
    logic [N-1:0]    win_oh;

    // Search order starts at base; the first requester in that order wins.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input int base);
        logic [IW-1:0] w;
        w = '0;
        for (int k = N - 1; k >= 0; k--)
            if (r[(base + k) % N]) w = IW'((base + k) % N);
        return w;
    endfunction

`ifdef DRAW_ARB_RR_EN
    logic [IW-1:0] ptr;
    always_comb win = pick(port.req, int'(ptr) + 1);
`else
    always_comb win = pick(port.req, 0);
`endif

    assign win_oh = N'(1) << win;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            g               <= '0;
            wd              <= '0;
            port.start      <= '0;
            port.grant      <= '0;
            port.x_out      <= '0;
            port.y_out      <= '0;
            port.colour_out <= '0;
            port.plot_out   <= 1'b0;
            port.busy       <= 1'b0;
            port.timeout    <= 1'b0;
`ifdef DRAW_ARB_RR_EN
            ptr             <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    port.plot_out <= 1'b0;
                    port.busy     <= 1'b0;
                    port.timeout  <= 1'b0;
                    if (|port.req) begin
                        g          <= win;
                        port.grant <= win_oh;
                        port.start <= win_oh;
                        port.busy  <= 1'b1;
                        state      <= LAUNCH;
`ifdef DRAW_ARB_RR_EN
                        ptr        <= win;
`endif
                    end
                end
                LAUNCH: begin
                    port.start <= '0;
                    wd         <= '0;
                    state      <= ACTIVE;
                end
                ACTIVE: begin
                    port.x_out      <= port.x_in[int'(g)*8 +: 8];
                    port.y_out      <= port.y_in[int'(g)*7 +: 7];
                    port.colour_out <= port.colour_in[int'(g)*3 +: 3];
                    port.plot_out   <= port.write_in[g];
                    // done takes precedence over a watchdog expiry in the same cycle
                    if (port.done[g]) begin
                        state <= RELEASE;
                    end else if (wd == WD_LIMIT) begin
                        state        <= RELEASE;
                        port.timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RELEASE: begin
                    port.plot_out <= 1'b0;
                    port.grant    <= '0;
                    port.busy     <= 1'b0;
                    port.timeout  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA pixel-plot port between N screen-drawing engines (start-screen drawer/eraser, end-screen drawer, sprite drawers).
- Each engine raises a request. The arbiter grants one engine at a time and gives it a one-cycle enable pulse to start its raster sweep.
- While granted, the engine's x/y/colour/write are registered onto the plot port. Ownership ends when the engine signals done or a watchdog expires.

Parameters:
- N, 4, number of requesting draw engines (2..8)
- TIMEOUT, 19216, maximum cycles a grant may be held (160x120 full-screen sweep plus margin)
- TO_W, 15, width of the watchdog counter; must hold TIMEOUT

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset
- req  input  N  per-engine draw request, level
- done  input  N  per-engine completion, level or pulse
- x_in  input  8*N  engine x coordinates, engine i at bits [8i+7:8i]
- y_in  input  7*N  engine y coordinates, engine i at bits [7i+6:7i]
- colour_in  input  3*N  engine colours, engine i at bits [3i+2:3i]
- write_in  input  N  engine pixel-write strobes
- start  output  N  one-cycle enable pulse to the granted engine
- grant  output  N  one-hot ownership, level
- x_out  output  8  plot x
- y_out  output  7  plot y
- colour_out  output  3  plot colour
- plot_out  output  1  plot write enable
- busy  output  1  high whenever any grant is held
- timeout  output  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (resetn low at a clock edge) takes effect at that edge, from any state including mid-grant.
  - start, grant, x_out, y_out, colour_out, plot_out, busy and timeout all go to 0.
  - FSM goes to IDLE, watchdog counter clears, round-robin pointer clears to 0.
- FSM states: IDLE, LAUNCH, ACTIVE, RELEASE.
- IDLE: plot_out=0, busy=0.
  - If req is nonzero at edge t, select the winner g by policy, go to LAUNCH.
  - At t+1: grant[g]=1, start[g]=1, busy=1.
- LAUNCH: lasts exactly one cycle.
  - start[g] deasserts at the next edge; go to ACTIVE; clear the watchdog.
  - done is ignored in LAUNCH, so stale done from the engine's previous run cannot end the new grant.
- ACTIVE: each cycle register x_in[g], y_in[g], colour_in[g] and write_in[g] into x_out, y_out, colour_out and plot_out.
  - Latency is one cycle from engine strobe to plot_out.
  - Non-granted engines' inputs never reach the port.
  - Watchdog increments by 1 per ACTIVE cycle.
- ACTIVE exit on done[g]=1: go to RELEASE. The pixel presented in the same cycle as done is still plotted on the following cycle.
- ACTIVE exit on watchdog reaching TIMEOUT-1 with done[g]=0: go to RELEASE and pulse timeout for one cycle.
- If done[g] and the watchdog limit coincide, done wins and timeout stays 0.
- done on any non-granted bit is ignored at all times.
- Dropping req[g] during ACTIVE does not end the grant; only done or the watchdog does.
- RELEASE: lasts one cycle.
  - plot_out=0, grant=0, busy=0; x_out/y_out/colour_out hold their last values.
  - Go to IDLE.
  - Earliest next grant: 3 cycles after done is sampled (RELEASE, IDLE arbitration, LAUNCH).
- Arbitration (default): fixed priority, lowest index wins. req changes outside IDLE are not sampled.
- Width rules: outputs are exact slices of the packed inputs, no truncation. The watchdog saturates at TIMEOUT-1 and never wraps.
- Invariants:
  - grant is always one-hot or zero.
  - start is a subset of grant.
  - plot_out=1 implies busy=1.

Optional Feature:
- DRAW_ARB_RR_EN defined: round-robin arbitration.
  - A pointer p (reset 0) records the last granted index.
  - The search starts at (p+1) mod N and wraps.
  - p updates to g on each LAUNCH.
- Undefined: fixed lowest-index priority as above, with no pointer logic.

Test Plan:
- Reset, then req=4'b0100 and hold engine 2 write_in=1 with x=5, y=9, colour=3'b001 for 3 cycles, then done[2]:
  - start[2] pulses exactly at t+1.
  - plot_out=1 with (5,9,001) appears one cycle after each strobe.
  - grant drops in RELEASE and busy=0.
- req=4'b1010 in IDLE:
  - Fixed priority grants engine 1, then engine 3 after done[1].
  - With DRAW_ARB_RR_EN: repeated req=4'b1010 alternates grants 1, 3, 1, 3.
- Engine granted, engine 3 toggles write_in and asserts done[3] while not granted -> plot_out and x_out never reflect engine 3; grant is unchanged.
- Granted engine never asserts done, with TIMEOUT=16 in the bench:
  - timeout pulses once, 16 ACTIVE cycles after LAUNCH.
  - grant clears and the next requester is served.
- resetn low for 1 cycle in the middle of ACTIVE, with plot_out=1 -> all outputs 0 at that edge; FSM in IDLE; a pending req is granted 1 cycle after resetn returns high.
- done[g] asserted in the same cycle the watchdog hits its limit -> RELEASE entered and timeout stays 0.
